// File: rtl/cache_pkg.sv
// cache_pkg: shared widths and the controller state type for the cache subsystem.
//   ADDR_W  - byte address width (RAM depth is 2**ADDR_W)
//   DATA_W  - data width, one byte per line
//   INDEX_W - index bits, line count is 2**INDEX_W
//   TAG_W   - tag bits, ADDR_W - INDEX_W
package cache_pkg;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned INDEX_W = 2;
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W;
    localparam int unsigned LINES   = 1 << INDEX_W;
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    typedef enum logic [1:0] {
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        FILL
    } state_e;

endpackage

// File: rtl/main_ram.sv
// main_ram: DEPTH x DATA_W backing store with synchronous write and registered read.
// A synchronous reset reloads every word with its own address (mem[i] = i) and clears
// the read register.
//   clk_i    - clock
//   rst_i    - synchronous active-high reset
//   we_i     - write strobe
//   re_i     - read strobe, loads rdata_o at the edge
//   addr_i   - word address
//   wdata_i  - write data
//   rdata_o  - registered read data, holds between reads
module main_ram
    import cache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= DATA_W'(i);
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cache.sv
// cache: direct-mapped, write-back, write-allocate cache in front of main_ram.
// One requester presents rw/addr/in and holds them while cacheMiss is high.
//   clock     - clock, all state on the rising edge
//   reset     - synchronous active-high reset
//   rw        - 0 = read, 1 = write
//   addr      - byte address {tag, index}
//   in        - write data
//   q         - registered read data, untouched by writes
//   cacheMiss - request not yet complete
//   ramRead   - RAM read strobe (ALLOCATE only)
//   ramWrite  - RAM write strobe (WRITEBACK only)
//   ramAddr   - RAM address of the current access
//   ramOut    - registered RAM read data
module cache
    import cache_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] q,
    output logic              cacheMiss,
    output logic              ramRead,
    output logic              ramWrite,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramOut
);

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [TAG_W-1:0]   tag_d  [LINES];
    logic [DATA_W-1:0]  data_q [LINES];
    logic [DATA_W-1:0]  data_d [LINES];
    logic [DATA_W-1:0]  q_q, q_d;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;

    assign idx = addr[INDEX_W-1:0];
    assign tag = addr[ADDR_W-1:INDEX_W];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        tag_d     = tag_q;
        data_d    = data_q;
        q_d       = q_q;
        cacheMiss = 1'b1;
        ramRead   = 1'b0;
        ramWrite  = 1'b0;
        ramAddr   = addr;

        unique case (state_q)
            COMPARE: begin
                cacheMiss = !hit;
                if (hit) begin
                    // A held request repeats here every cycle; both actions are idempotent.
                    if (rw) begin
                        data_d[idx]  = in;
                        dirty_d[idx] = 1'b1;
                    end else begin
                        q_d = data_q[idx];
                    end
                end else if (valid_q[idx] && dirty_q[idx]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                ramWrite = 1'b1;
                ramAddr  = {tag_q[idx], idx};
                state_d  = ALLOCATE;
            end
            ALLOCATE: begin
                ramRead = 1'b1;
                state_d = FILL;
            end
            FILL: begin
                // A write miss lands later, on the COMPARE hit that follows.
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b0;
                tag_d[idx]   = tag;
                data_d[idx]  = ramOut;
                state_d      = COMPARE;
            end
            default: state_d = COMPARE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= COMPARE;
            valid_q <= '0;
            dirty_q <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            q_q     <= q_d;
        end
    end

    // Tag and data contents are qualified by valid, so they need no reset.
    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign q = q_q;

    main_ram u_main_ram (
        .clk_i   (clock),
        .rst_i   (reset),
        .we_i    (ramWrite),
        .re_i    (ramRead),
        .addr_i  (ramAddr),
        .wdata_i (data_q[idx]),
        .rdata_o (ramOut)
    );

endmodule

// File: tb/tb_cache.sv
// tb_cache: directed bench for cache. A small reference model (coherent memory image plus
// per-line valid/dirty/tag) predicts latency, RAM traffic, ramOut and q for each request;
// expected q values go through a scoreboard queue and are popped on completion.
module tb_cache;

    logic       clock;
    logic       reset;
    logic       rw;
    logic [4:0] addr;
    logic [7:0] in;
    logic [7:0] q;
    logic       cacheMiss;
    logic       ramRead;
    logic       ramWrite;
    logic [4:0] ramAddr;
    logic [7:0] ramOut;

    cache dut (
        .clock     (clock),
        .reset     (reset),
        .rw        (rw),
        .addr      (addr),
        .in        (in),
        .q         (q),
        .cacheMiss (cacheMiss),
        .ramRead   (ramRead),
        .ramWrite  (ramWrite),
        .ramAddr   (ramAddr),
        .ramOut    (ramOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    // RAM traffic monitor, sampled away from the active edge.
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    logic [4:0] rd_addr_seen = '0;
    logic [4:0] wr_addr_seen = '0;

    always @(negedge clock) begin
        if (ramRead === 1'b1) begin
            rd_cnt++;
            rd_addr_seen = ramAddr;
        end
        if (ramWrite === 1'b1) begin
            wr_cnt++;
            wr_addr_seen = ramAddr;
        end
    end

    // Reference model.
    logic [7:0] model_mem [32];
    bit         m_valid [4];
    bit         m_dirty [4];
    logic [2:0] m_tag   [4];
    logic [7:0] last_q;
    logic [7:0] sb_q [$];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_mem[i] = 8'(i);
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        last_q = 8'h00;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [4:0] a, input logic [7:0] d);
        int         idx;
        int         exp_lat;
        int         exp_rd;
        int         exp_wr;
        logic [4:0] exp_wa;
        logic [7:0] exp_ro;
        logic [7:0] exp_q;
        logic [7:0] got_q;
        int         rd0;
        int         wr0;
        int         cycles;

        idx    = int'(a[1:0]);
        exp_wa = '0;
        exp_ro = model_mem[a];
        if (m_valid[idx] && m_tag[idx] == a[4:2]) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (m_valid[idx] && m_dirty[idx]) begin
            exp_lat = 5; exp_rd = 1; exp_wr = 1;
            exp_wa  = {m_tag[idx], a[1:0]};
        end else begin
            exp_lat = 4; exp_rd = 1; exp_wr = 0;
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a[4:2];
        if (exp_lat != 1) m_dirty[idx] = 1'b0;
        if (w) begin
            m_dirty[idx] = 1'b1;
            model_mem[a] = d;
        end else begin
            last_q = model_mem[a];
        end
        sb_q.push_back(last_q);

        rd0 = rd_cnt;
        wr0 = wr_cnt;
        rw   = w;
        addr = a;
        in   = d;
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (cacheMiss !== 1'b0 && cycles < 12);
        @(posedge clock);
        #1;

        check($sformatf("latency a=%0d", a), 32'(cycles), 32'(exp_lat));
        check($sformatf("ramRead count a=%0d", a), 32'(rd_cnt - rd0), 32'(exp_rd));
        check($sformatf("ramWrite count a=%0d", a), 32'(wr_cnt - wr0), 32'(exp_wr));
        if (exp_rd == 1) begin
            check($sformatf("ramRead addr a=%0d", a), 32'(rd_addr_seen), 32'(a));
            check($sformatf("ramOut a=%0d", a), 32'(ramOut), 32'(exp_ro));
        end
        if (exp_wr == 1) begin
            check($sformatf("ramWrite addr a=%0d", a), 32'(wr_addr_seen), 32'(exp_wa));
        end
        got_q = sb_q.pop_front();
        check($sformatf("q after %s a=%0d", w ? "write" : "read", a), 32'(q), 32'(got_q));
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        rw    = 1'b0;
        addr  = 5'd20;
        in    = 8'h00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset q", 32'(q), 32'h00);
        check("reset ramOut", 32'(ramOut), 32'h00);
        check("reset cacheMiss (all lines invalid)", 32'(cacheMiss), 32'h1);
        check("reset strobes", 32'({ramRead, ramWrite}), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Cold read, clean conflict, then hits and a dirty eviction.
        do_req(1'b0, 5'd20, 8'h00);
        do_req(1'b0, 5'd21, 8'h00);
        do_req(1'b0, 5'd25, 8'h00);
        do_req(1'b0, 5'd20, 8'h00);
        do_req(1'b0, 5'd28, 8'h00);
        do_req(1'b1, 5'd28, 8'hFF);
        do_req(1'b0, 5'd28, 8'h00);
        do_req(1'b1, 5'd0,  8'd10);
        do_req(1'b0, 5'd28, 8'h00);

        for (int i = 1; i <= 4; i++) do_req(1'b1, 5'(i), 8'(10 + i));
        for (int i = 0; i <= 4; i++) do_req(1'b0, 5'(i), 8'h00);

        // Dirty line at index 1, then reset while its write-back is in flight.
        do_req(1'b1, 5'd5, 8'h55);
        rw   = 1'b0;
        addr = 5'd9;
        @(negedge clock);
        check("conflict miss seen", 32'(cacheMiss), 32'h1);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("in WRITEBACK ramWrite", 32'(ramWrite), 32'h1);
        check("in WRITEBACK ramAddr", 32'(ramAddr), 32'd5);
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("post-reset strobes", 32'({ramRead, ramWrite}), 32'h0);
        check("post-reset cacheMiss", 32'(cacheMiss), 32'h1);
        check("post-reset q", 32'(q), 32'h00);
        check("post-reset ramOut", 32'(ramOut), 32'h00);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        do_req(1'b0, 5'd9,  8'h00);
        do_req(1'b0, 5'd5,  8'h00);
        do_req(1'b0, 5'd28, 8'h00);
        do_req(1'b0, 5'd0,  8'h00);
        do_req(1'b0, 5'd31, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
